// File: rtl/wb_pkg.sv
// Shared encodings, state/kind enums and the retire-queue entry layout for the
// writeback/commit stage.
package wb_pkg;

    localparam int XMAX = 64;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [4:0]  OPC_BRANCH = 5'b11000;
    localparam logic [4:0]  OPC_JALR   = 5'b11001;
    localparam logic [4:0]  OPC_JAL    = 5'b11011;

    localparam logic [31:0] ECALL_ENC  = 32'h00000073;
    localparam logic [31:0] MRET_ENC   = 32'h30200073;
    localparam logic [31:0] SRET_ENC   = 32'h10200073;

    localparam int          CAUSE_BASE = 8;

    typedef enum logic [1:0] {RUN, TRAP, REDIRECT} wb_state_e;

    typedef enum logic [2:0] {K_NORMAL, K_CSR, K_CTRL, K_ECALL, K_XRET} wb_kind_e;

    // Fields are held at full 64-bit width; narrower datapaths use the low bits.
    typedef struct packed {
        logic [31:0]     ir;
        logic [XMAX-1:0] res;
        logic [XMAX-1:0] target;
        logic            pc_mux;
        logic            reg_wen;
        logic            w;
        logic [XMAX-1:0] csrfd;
    } wb_entry_t;

    function automatic wb_kind_e classify(input logic [31:0] ir);
        wb_kind_e k;
        k = K_NORMAL;
        if (ir == ECALL_ENC)                             k = K_ECALL;
        else if (ir == MRET_ENC || ir == SRET_ENC)       k = K_XRET;
        else if (ir[6:0] == OPC_SYSTEM)                  k = K_CSR;
        else if (ir[6:2] == OPC_BRANCH || ir[6:2] == OPC_JALR || ir[6:2] == OPC_JAL)
                                                         k = K_CTRL;
        return k;
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// Memory-stage / register-file / fetch-redirect signal bundle of the commit stage.
interface wb_commit_unit_if #(parameter int XLEN = 64);

    logic            WB_V;
    logic            WB_READY;
    logic [31:0]     WB_IR;
    logic [XLEN-1:0] WB_RES;
    logic [XLEN-1:0] WB_Target_Address;
    logic            WB_PC_MUX;
    logic            WB_REG_WEN;
    logic            WB_W;
    logic [XLEN-1:0] WB_CSRFD;
    logic [1:0]      DE_WB_PRIVILEGE;
    logic [XLEN-1:0] TRAP_VEC;
    logic [XLEN-1:0] EPC;
    logic            RF_READY;
    logic            OUT_DE_REG_WEN;
    logic [4:0]      OUT_DE_DR;
    logic [XLEN-1:0] OUT_DE_Data;
    logic            OUT_DE_ST_CSR;
    logic [XLEN-1:0] OUT_DE_CSR_DATA;
    logic            OUT_FE_PC_MUX;
    logic [XLEN-1:0] OUT_FE_Target_Address;
    logic            OUT_FLUSH;
    logic            OUT_DE_CS;
    logic [XLEN-1:0] OUT_DE_CAUSE;
    logic            V_WB_FE_TRAP_STALL;

    modport master (
        output WB_V, WB_IR, WB_RES, WB_Target_Address, WB_PC_MUX, WB_REG_WEN, WB_W,
               WB_CSRFD, DE_WB_PRIVILEGE, TRAP_VEC, EPC, RF_READY,
        input  WB_READY, OUT_DE_REG_WEN, OUT_DE_DR, OUT_DE_Data, OUT_DE_ST_CSR,
               OUT_DE_CSR_DATA, OUT_FE_PC_MUX, OUT_FE_Target_Address, OUT_FLUSH,
               OUT_DE_CS, OUT_DE_CAUSE, V_WB_FE_TRAP_STALL
    );

    modport slave (
        input  WB_V, WB_IR, WB_RES, WB_Target_Address, WB_PC_MUX, WB_REG_WEN, WB_W,
               WB_CSRFD, DE_WB_PRIVILEGE, TRAP_VEC, EPC, RF_READY,
        output WB_READY, OUT_DE_REG_WEN, OUT_DE_DR, OUT_DE_Data, OUT_DE_ST_CSR,
               OUT_DE_CSR_DATA, OUT_FE_PC_MUX, OUT_FE_Target_Address, OUT_FLUSH,
               OUT_DE_CS, OUT_DE_CAUSE, V_WB_FE_TRAP_STALL
    );

endinterface

// File: rtl/wb_retire_fifo.sv
// Retire queue: DEPTH-entry circular FIFO with push, pop and a whole-queue flush.
module wb_retire_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  wb_entry_t din_i,
    output wb_entry_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    wb_entry_t     mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is data only; occupancy tracking decides what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: retire queue, register/CSR commit, branch flush and
// ECALL/xRET trap sequencing. Optional retired-instruction counter: WB_INSTRET_EN.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    wb_commit_unit_if.slave        bus
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]            INSTRET
`endif
);

    wb_state_e       state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    wb_entry_t       din, head;
    wb_kind_e        kind;
    logic            empty, full, retire, taken, flush, push;

    logic            reg_wen, st_csr, pc_mux, flush_o, cs, stall;
    logic [4:0]      dr;
    logic [XLEN-1:0] data, csr_data, fe_tgt, cause;

    function automatic logic [XLEN-1:0] wb_data(input wb_entry_t e);
        logic signed [31:0] r32;
        r32 = e.res[31:0];
        return e.w ? XLEN'(r32) : e.res[XLEN-1:0];
    endfunction

    assign din.ir      = bus.WB_IR;
    assign din.res     = XMAX'(bus.WB_RES);
    assign din.target  = XMAX'(bus.WB_Target_Address);
    assign din.pc_mux  = bus.WB_PC_MUX;
    assign din.reg_wen = bus.WB_REG_WEN;
    assign din.w       = bus.WB_W;
    assign din.csrfd   = XMAX'(bus.WB_CSRFD);

    assign kind   = classify(head.ir);
    assign retire = (state_q == RUN) && !empty && bus.RF_READY;
    assign taken  = retire && (kind == K_CTRL) && head.pc_mux;
    assign flush  = taken || (state_q == TRAP);
    assign push   = bus.WB_V && bus.WB_READY;

    wb_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push),
        .pop_i   (retire),
        .flush_i (flush),
        .din_i   (din),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        tgt_q <= tgt_d;
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        reg_wen  = 1'b0;
        dr       = '0;
        data     = '0;
        st_csr   = 1'b0;
        csr_data = '0;
        pc_mux   = 1'b0;
        fe_tgt   = '0;
        flush_o  = 1'b0;
        cs       = 1'b0;
        cause    = '0;
        stall    = 1'b0;
        case (state_q)
            RUN: begin
                if (retire) begin
                    case (kind)
                        K_ECALL: state_d = TRAP;
                        K_XRET: begin
                            state_d = REDIRECT;
                            tgt_d   = bus.EPC;
                        end
                        default: begin
                            reg_wen = head.reg_wen && (head.ir[11:7] != 5'd0);
                            dr      = head.ir[11:7];
                            data    = wb_data(head);
                            if (kind == K_CSR) begin
                                st_csr   = 1'b1;
                                csr_data = head.csrfd[XLEN-1:0];
                            end
                            if (taken) begin
                                pc_mux  = 1'b1;
                                fe_tgt  = head.target[XLEN-1:0];
                                flush_o = 1'b1;
                            end
                        end
                    endcase
                end
            end
            TRAP: begin
                cs      = 1'b1;
                cause   = XLEN'(CAUSE_BASE) + XLEN'(bus.DE_WB_PRIVILEGE);
                flush_o = 1'b1;
                stall   = 1'b1;
                tgt_d   = bus.TRAP_VEC;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_mux  = 1'b1;
                fe_tgt  = tgt_q;
                stall   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.WB_READY              = !full && (state_q == RUN);
    assign bus.OUT_DE_REG_WEN        = reg_wen;
    assign bus.OUT_DE_DR             = dr;
    assign bus.OUT_DE_Data           = data;
    assign bus.OUT_DE_ST_CSR         = st_csr;
    assign bus.OUT_DE_CSR_DATA       = csr_data;
    assign bus.OUT_FE_PC_MUX         = pc_mux;
    assign bus.OUT_FE_Target_Address = fe_tgt;
    assign bus.OUT_FLUSH             = flush_o;
    assign bus.OUT_DE_CS             = cs;
    assign bus.OUT_DE_CAUSE          = cause;
    assign bus.V_WB_FE_TRAP_STALL    = stall;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       instret_q <= '0;
        else if (retire) instret_q <= instret_q + 64'd1;
    end

    assign INSTRET = instret_q;
`endif

endmodule
